// File: rtl/v6523_pkg.sv
// Shared types and constants for the V6523 bus-cycle sequencer.
// Register selects at or above RS_NULL_MIN decode to no device register.
package v6523_pkg;

  localparam logic [2:0] RS_PRA      = 3'd0;
  localparam logic [2:0] RS_PRB      = 3'd1;
  localparam logic [2:0] RS_PRC      = 3'd2;
  localparam logic [2:0] RS_DDRA     = 3'd3;
  localparam logic [2:0] RS_DDRB     = 3'd4;
  localparam logic [2:0] RS_DDRC     = 3'd5;
  localparam logic [2:0] RS_NULL_MIN = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  function automatic logic is_null_rs(input logic [2:0] rs);
    return (rs >= RS_NULL_MIN);
  endfunction

endpackage

// File: rtl/v6523_rr_arb2.sv
// Two-input round-robin arbiter; last_r remembers the most recent winner (1 after reset).
module v6523_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_r;

  // Grant decode: on a tie the requester that did not win last time goes first
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_r ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

  // Winner pointer, moved only when a grant is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (|grant) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/v6523_bus_seq.sv
// Two-port request arbiter and 6523 bus-cycle sequencer (SETUP, STROBE x N, HOLD).
// Bus pins are registered from the next-state decode so they line up with the state they belong to.
module v6523_bus_seq
  import v6523_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rw,
  input  logic [2:0] req0_rs,
  input  logic [7:0] req0_wdata,
  output logic       req0_ack,
  output logic       req0_done,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic       req1_rw,
  input  logic [2:0] req1_rs,
  input  logic [7:0] req1_wdata,
  output logic       req1_ack,
  output logic       req1_done,
  output logic [7:0] req1_rdata,
  output logic       bus_cs_n,
  output logic       bus_r_w,
  output logic [2:0] bus_rs,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_in
);

  seq_state_t state_r, state_next_s;
  logic [1:0] grant_s;
  logic [3:0] cnt_r;
  logic       rw_r, null_r, win_r;
  logic [1:0] done_r;
  logic [7:0] rdata0_r, rdata1_r;
  logic       sel_rw_s, sel_null_s;
  logic [2:0] sel_rs_s;
  logic [7:0] sel_wdata_s;
  logic       cs_n_s, r_w_s, oe_s;
  logic [2:0] rs_s;
  logic [7:0] dout_s;
  logic       bus_cs_n_r, bus_r_w_r, bus_data_oe_r;
  logic [2:0] bus_rs_r;
  logic [7:0] bus_data_out_r;
  logic       last_strobe_s;

  v6523_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    ({req1_valid, req0_valid}),
    .grant_en (state_r == IDLE),
    .grant    (grant_s)
  );

  // Ack is the arbiter grant itself so fields are captured in the very cycle the requester sees ack
  assign req0_ack      = grant_s[0];
  assign req1_ack      = grant_s[1];
  assign sel_rw_s      = grant_s[1] ? req1_rw    : req0_rw;
  assign sel_rs_s      = grant_s[1] ? req1_rs    : req0_rs;
  assign sel_wdata_s   = grant_s[1] ? req1_wdata : req0_wdata;
  assign sel_null_s    = is_null_rs(sel_rs_s);
  assign last_strobe_s = (cnt_r <= 4'd1);

  // Next state and next bus-pin values
  always_comb begin
    state_next_s = state_r;
    cs_n_s       = 1'b1;
    r_w_s        = bus_r_w_r;
    rs_s         = bus_rs_r;
    dout_s       = bus_data_out_r;
    oe_s         = bus_data_oe_r;
    case (state_r)
      IDLE: begin
        oe_s  = 1'b0;
        r_w_s = 1'b1;
        if (|grant_s) begin
          if (sel_null_s) begin
            state_next_s = HOLD;
          end else begin
            state_next_s = SETUP;
            r_w_s        = sel_rw_s;
            rs_s         = sel_rs_s;
            oe_s         = ~sel_rw_s;
            dout_s       = sel_rw_s ? bus_data_out_r : sel_wdata_s;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = STROBE;
        cs_n_s       = 1'b0;
      end
      STROBE: begin
        if (last_strobe_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = STROBE;
          cs_n_s       = 1'b0;
        end
      end
      HOLD: begin
        state_next_s = IDLE;
        oe_s         = 1'b0;
        r_w_s        = 1'b1;
      end
      default: begin
        state_next_s = IDLE;
        oe_s         = 1'b0;
        r_w_s        = 1'b1;
      end
    endcase
  end

  // State and bus pin registers; reset releases the device bus immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      bus_cs_n_r     <= 1'b1;
      bus_r_w_r      <= 1'b1;
      bus_rs_r       <= 3'd0;
      bus_data_out_r <= 8'd0;
      bus_data_oe_r  <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      bus_cs_n_r     <= cs_n_s;
      bus_r_w_r      <= r_w_s;
      bus_rs_r       <= rs_s;
      bus_data_out_r <= dout_s;
      bus_data_oe_r  <= oe_s;
    end
  end

  // Request capture, strobe counter, done pulse and read-data return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_r     <= 1'b1;
      null_r   <= 1'b0;
      win_r    <= 1'b0;
      cnt_r    <= 4'd0;
      done_r   <= 2'b00;
      rdata0_r <= 8'd0;
      rdata1_r <= 8'd0;
    end else begin
      if (|grant_s) begin
        rw_r   <= sel_rw_s;
        null_r <= sel_null_s;
        win_r  <= grant_s[1];
      end
      if (state_r == SETUP) begin
        cnt_r <= 4'(STROBE_CYCLES);
      end else if (state_r == STROBE) begin
        cnt_r <= cnt_r - 4'd1;
      end
      done_r <= (state_r == HOLD) ? {win_r, ~win_r} : 2'b00;
      if ((state_r == STROBE) && last_strobe_s && rw_r) begin
        if (win_r) rdata1_r <= bus_data_in;
        else       rdata0_r <= bus_data_in;
      end else if ((state_r == HOLD) && null_r && rw_r) begin
        if (win_r) rdata1_r <= 8'hFF;
        else       rdata0_r <= 8'hFF;
      end
    end
  end

  assign req0_done    = done_r[0];
  assign req1_done    = done_r[1];
  assign req0_rdata   = rdata0_r;
  assign req1_rdata   = rdata1_r;
  assign bus_cs_n     = bus_cs_n_r;
  assign bus_r_w      = bus_r_w_r;
  assign bus_rs       = bus_rs_r;
  assign bus_data_out = bus_data_out_r;
  assign bus_data_oe  = bus_data_oe_r;

endmodule
